// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over a
// valid-qualified handshake, and picks the next PC from jump/branch controls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        zero,
  input  logic        PCSrc,
  input  logic        stall,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_plus4_w;

  // Jump keeps the upper nibble of pc+4; branch offset is a signed word count.
  function automatic logic [31:0] next_pc(input logic [31:0] p4,
                                          input logic [25:0] target,
                                          input logic        jmp,
                                          input logic        taken);
    logic signed [31:0] off;
    off = {{14{target[15]}}, target[15:0], 2'b00};
    if (jmp)
      return {p4[31:28], target, 2'b00};
    else if (taken)
      return p4 + $unsigned(off);
    else
      return p4;
  endfunction

  assign pc_plus4_w = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
      pc_q    <= RESET_PC;
      ins_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // A response on the final wait edge still wins over the timeout.
        if (imem_valid) begin
          ins_d   = imem_rdata;
          wait_d  = 8'd0;
          state_d = S_EXEC;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) state_d = S_ERR;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d    = next_pc(pc_plus4_w, ins_q[25:0], PCSrc, Branch && zero);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == S_FETCH);
    ins_valid = (state_q == S_EXEC);
    fetch_err = (state_q == S_ERR);
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_plus4_w;
  assign ins       = ins_q;

endmodule
